// File: rtl/bus_arbiter_4i_if.sv
// Operand-bus bundle between the four requesters and bus_arbiter_4i.
// slave = arbiter side, master = requester/consumer side.
interface bus_arbiter_4i_if #(
    parameter int unsigned WIDTH = 16
);
    logic [3:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data3;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       sel;
    logic [3:0]       ack;
    logic             busy;

    modport slave (
        input  req, data0, data1, data2, data3, out_ready,
        output out_valid, out_data, sel, ack, busy
    );

    modport master (
        output req, data0, data1, data2, data3, out_ready,
        input  out_valid, out_data, sel, ack, busy
    );
endinterface

// File: rtl/bus_arbiter_4i.sv
// Four-requester operand-bus arbiter with registered winner word and valid/ready output.
// ARB_ROUND_ROBIN_EN selects round-robin priority; otherwise fixed priority 0>1>2>3.
module bus_arbiter_4i #(
    parameter int unsigned WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    bus_arbiter_4i_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_sel;

    logic [1:0]       w_winner;
    logic [WIDTH-1:0] w_win_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_last;
    logic [3:0] w_rot;
    logic [1:0] w_off;

    // Rotate requests so bit 0 is the requester just after the last grant.
    always_comb begin
        w_rot = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            w_rot[j] = bus.req[2'(r_last + 2'(j) + 2'd1)];
        end
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            default: w_off = 2'd3;
        endcase
        w_winner = 2'(r_last + 2'd1 + w_off);
    end
`else
    always_comb begin
        casez (bus.req)
            4'b???1: w_winner = 2'd0;
            4'b??10: w_winner = 2'd1;
            4'b?100: w_winner = 2'd2;
            default: w_winner = 2'd3;
        endcase
    end
`endif

    always_comb begin
        unique case (w_winner)
            2'd0: w_win_data = bus.data0;
            2'd1: w_win_data = bus.data1;
            2'd2: w_win_data = bus.data2;
            2'd3: w_win_data = bus.data3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel       <= 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last      <= 2'd3;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|bus.req) begin
                        r_sel       <= w_winner;
                        r_out_data  <= w_win_data;
                        r_out_valid <= 1'b1;
                        r_state     <= StBusy;
                    end
                end
                StBusy: begin
                    // Word is already captured; requests and data are ignored until consumed.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last      <= r_sel;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.sel       = r_sel;
    assign bus.busy      = (r_state == StBusy);
    assign bus.ack       = (r_out_valid && bus.out_ready) ? (4'b0001 << r_sel) : 4'b0000;
endmodule

// File: tb/tb_bus_arbiter_4i.sv
// Self-checking bench for bus_arbiter_4i: vector table, scoreboard, and corner-case sequences.
module tb_bus_arbiter_4i;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_arbiter_4i_if #(.WIDTH(W)) bus ();
    bus_arbiter_4i #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]   req;
        logic [W-1:0] base;
        logic [1:0]   exp_sel;
    } vec_t;

    exp_t       sb_q[$];
    logic [1:0] grants[$];
    vec_t       vecs[8];
    int         total = 0;
    int         bad = 0;
    logic       m_valid;
    logic [1:0] m_sel;
    logic [1:0] m_last;
    logic       hs;
    logic [1:0] hs_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
`ifdef ARB_ROUND_ROBIN_EN
        logic [1:0] idx;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'((int'(last) + k) % 4);
            if (r[idx]) return idx;
        end
        return 2'd0;
`else
        for (int k = 0; k < 4; k++) begin
            if (r[k]) return 2'(k);
        end
        return last;
`endif
    endfunction

    function automatic logic [W-1:0] data_of(input logic [1:0] i);
        case (i)
            2'd0:    return bus.data0;
            2'd1:    return bus.data1;
            2'd2:    return bus.data2;
            default: return bus.data3;
        endcase
    endfunction

    task automatic reset_model();
        m_valid = 1'b0;
        m_sel   = 2'd0;
        m_last  = 2'd3;
        hs      = 1'b0;
        sb_q.delete();
    endtask

    task automatic set_data(input logic [W-1:0] base);
        bus.data0 = base;
        bus.data1 = base ^ 16'h1111;
        bus.data2 = base ^ 16'h2222;
        bus.data3 = base ^ 16'h3333;
    endtask

    // Checks the cycle whose inputs are now driven, then advances the model across the edge.
    task automatic monitor();
        exp_t e;
        #1;
        hs = 1'b0;
        chk("out_valid", bus.out_valid, m_valid);
        chk("busy", bus.busy, m_valid);
        if (m_valid) begin
            chk("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                e = sb_q[0];
                chk("sel", bus.sel, e.sel);
                chk("out_data", bus.out_data, e.data);
            end
        end
        if (m_valid && bus.out_ready) begin
            chk("ack_hs", bus.ack, 4'b0001 << m_sel);
            hs     = 1'b1;
            hs_sel = m_sel;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            m_valid = 1'b0;
            m_last  = m_sel;
        end else begin
            chk("ack_zero", bus.ack, 4'b0000);
            if (!m_valid && bus.req != 4'b0000) begin
                m_sel = pick(bus.req, m_last);
                sb_q.push_back({m_sel, data_of(m_sel)});
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic tick();
        monitor();
        @(negedge clk);
    endtask

    initial begin
        int n_hs;
        int n_three;
        vecs[0] = '{4'b0001, 16'h0101, 2'd0};
        vecs[1] = '{4'b0100, 16'h0202, 2'd2};
        vecs[2] = '{4'b1000, 16'h0303, 2'd3};
        vecs[3] = '{4'b0110, 16'h0404, 2'd1};
        vecs[4] = '{4'b1100, 16'h0505, 2'd2};
        vecs[5] = '{4'b1010, 16'h0606, 2'd1};
        vecs[6] = '{4'b1111, 16'h0707, 2'd0};
        vecs[7] = '{4'b0011, 16'h0808, 2'd0};

        // Reset held with every requester active and the consumer ready.
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        set_data(16'hA5A5);
        reset_model();
        @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sel", bus.sel, 2'd0);
        chk("rst_ack", bus.ack, 4'b0000);
        chk("rst_out_data", bus.out_data, 16'h0000);
        chk("rst_busy", bus.busy, 1'b0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        chk("post_rst_sel", bus.sel, 2'd0);
        chk("post_rst_data", bus.out_data, 16'hA5A5);
        bus.out_ready = 1'b1;
        tick();
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();

        // Vector table: one isolated transaction per entry.
        foreach (vecs[v]) begin
            set_data(vecs[v].base);
            bus.req       = vecs[v].req;
            bus.out_ready = 1'b0;
            tick();
`ifndef ARB_ROUND_ROBIN_EN
            chk("vec_sel", bus.sel, vecs[v].exp_sel);
`endif
            bus.out_ready = 1'b1;
            tick();
            bus.req       = 4'b0000;
            bus.out_ready = 1'b0;
            tick();
        end

        // Single request with out_ready already high: one-cycle latency, first-BUSY handshake.
        set_data(16'h0000);
        bus.data2     = 16'hBEEF;
        bus.req       = 4'b0100;
        bus.out_ready = 1'b1;
        tick();
        chk("single_sel", bus.sel, 2'd2);
        chk("single_data", bus.out_data, 16'hBEEF);
        tick();
        chk("single_hs", hs, 1'b1);
        bus.req = 4'b0000;
        tick();
        tick();

        // Backpressure: captured word must not follow data0.
        bus.data0     = 16'h1234;
        bus.req       = 4'b0001;
        bus.out_ready = 1'b0;
        tick();
        bus.data0 = 16'hFFFF;
        for (int c = 0; c < 5; c++) tick();
        chk("bp_data", bus.out_data, 16'h1234);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_hs", hs, 1'b1);
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();

        // Requester drops req while BUSY; ack still fires on the handshake.
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        bus.out_ready = 1'b1;
        tick();
        chk("drop_hs_sel", hs_sel, 2'd1);
        bus.out_ready = 1'b0;
        tick();

        // All four request; each drops after its ack.
        set_data(16'h7000);
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        grants.delete();
        for (int c = 0; c < 12; c++) begin
            tick();
            if (hs) begin
                grants.push_back(hs_sel);
                bus.req[hs_sel] = 1'b0;
            end
        end
        chk("all4_count", grants.size(), 4);
        for (int g = 0; g < 4 && g < grants.size(); g++) chk("all4_order", grants[g], g);
        bus.req = 4'b1111;
        tick();
        tick();
        chk("rereq_sel", hs_sel, 2'd0);
        bus.req = 4'b0000;
        tick();

        // 1 and 3 request continuously.
        bus.req = 4'b1010;
        n_hs    = 0;
        n_three = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (hs) begin
                n_hs++;
                if (hs_sel == 2'd3) n_three++;
            end
        end
        chk("pair_hs", n_hs, 4);
`ifdef ARB_ROUND_ROBIN_EN
        chk("pair_three", n_three, 2);
`else
        chk("pair_three", n_three, 0);
`endif
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset during BUSY on requester 3: transfer abandoned, no ack.
        bus.req = 4'b1000;
        tick();
        tick();
        chk("midrst_pre_sel", bus.sel, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_sel", bus.sel, 2'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("midrst_ack", bus.ack, 4'b0000);
        reset_model();
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        bus.req = 4'b1000;
        tick();
        tick();
        chk("midrst_rereq", hs_sel, 2'd3);
        bus.req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_4i.md
# bus_arbiter_4i

Four-requester arbiter for the shared 16-bit operand bus of the multi-register accumulator datapath. It samples four request/data pairs, chooses one winner, and drives the 2-bit select that steers the 4-input bus multiplexer. It captures the winner's word into an output register and holds it under a valid/ready handshake until the accumulator consumes it. It returns a one-hot acknowledge to the served requester.

## Interface
- WIDTH, 16, data width of every requester word and of the output word
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk
- req  input  4  request per requester, bit i = requester i
- data0, data1, data2, data3  input  WIDTH each  requester words, valid while the matching req bit is high
- out_ready  input  1  consumer (accumulator) accepts out_data this cycle
- out_valid  output  1  out_data holds a granted word
- out_data  output  WIDTH  registered word of the current winner
- sel  output  2  registered index of the current/last winner; drives the bus mux select
- ack  output  4  one-hot, combinational: ack[sel] = out_valid & out_ready
- busy  output  1  high in state BUSY

## Operation
- States: IDLE, BUSY. Reset state is IDLE.
- IDLE, req == 0: remain in IDLE; outputs unchanged.
- IDLE, req != 0: pick a winner w per the priority rule. At the edge: sel <= w, out_data <= data_w, out_valid <= 1, state <= BUSY.
- BUSY, out_ready == 0: hold everything. out_data stays stable even if data_w or req changes.
- BUSY, out_ready == 1: ack[sel] = 1 this cycle. At the edge: out_valid <= 0, state <= IDLE, and the last-grant pointer is updated to sel.
- Requesters hold req and data until they see their ack bit, then drop req at the next edge.
- A requester that drops req while in BUSY before its ack has no effect on the transfer: the word is already captured, and ack still fires on the handshake.
- Requests arriving during BUSY are held off and considered only in the next IDLE cycle.
- Priority (round-robin build): search order starts at last+1 mod 4 and wraps 3->0. The pointer resets to 3, so requester 0 wins first.
- Priority (fixed build): requester 0 highest, then 1, 2, 3.
- ack is zero whenever out_valid == 0. At most one ack bit is high.

## Timing
- Reset values: out_valid 0, out_data 0, sel 0, busy 0, ack 0, pointer 3, state IDLE.
- Latency: request seen in IDLE cycle T -> out_valid high from cycle T+1.
- Handshake: completes in the first BUSY cycle with out_ready high, at the earliest cycle T+1.
- Throughput: at most one word per 2 cycles, because BUSY always returns through IDLE.
- out_ready high while out_valid is low is ignored.
- Reset asserted in BUSY: the transfer is abandoned with no ack, all registers take their reset values, and requesters must re-request.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin priority with the last-grant pointer described above.
- ARB_ROUND_ROBIN_EN undefined: fixed priority 0>1>2>3. The pointer register is not built, and all other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 -> out_valid=0, sel=0, ack=0. Release; next edge -> sel=0, out_data=data0.
- Single request: req=4'b0100, data2=16'hBEEF, out_ready=1 -> out_valid at T+1, out_data=16'hBEEF, sel=2, ack=4'b0100 for one cycle, then IDLE.
- Backpressure: req=4'b0001, data0=16'h1234, out_ready=0 for 5 cycles while data0 changes to 16'hFFFF -> out_data stays 16'h1234, ack=0. Raise out_ready -> ack=4'b0001.
- Round-robin (macro defined): req=4'b1111 held, each requester dropping req after its ack, out_ready=1 -> grant order 0,1,2,3, then 0 again on re-request.
- Fixed priority (macro undefined): req=4'b1010 held continuously -> requester 1 is granted every time; 3 is never granted while 1 requests.
- Reset mid-transfer: BUSY with sel=3, out_ready=0; pulse rst_n low -> out_valid=0 immediately, no ack bit ever asserted, state IDLE.
